// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader that fills instruction memory and releases the core on a valid checksum
module imem_loader #(
    parameter int ADDR_W = 7,
    parameter int MAX_WORDS = 128,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_RUN    = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;
    localparam logic [ADDR_W:0] WL_ONE = 1;

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W:0]   n_q, n_d;
    logic [7:0]        sum_q, sum_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W:0]   wl_q, wl_d;
    logic              in_ready_q, imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;
    logic              cpu_rst_q, cpu_rst_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              acc, sync;
    logic [15:0]       len_w;
    logic [ADDR_W:0]   wl_inc;

    always_comb begin
        acc = in_valid && in_ready_q;
        sync = acc && (in_data == SYNC_BYTE);
        len_w = {in_data, len_lo_q};
        wl_inc = wl_q + WL_ONE;
        state_d = state_q;
        len_lo_d = len_lo_q;
        n_d = n_q;
        sum_d = sum_q;
        idx_d = idx_q;
        word_d = word_q;
        wl_d = wl_q;
        imem_we_d = 1'b0;
        addr_d = addr_q;
        din_d = din_q;
        case (state_q)
            S_LEN_LO: if (acc) begin
                len_lo_d = in_data;
                sum_d = sum_q + in_data;
                state_d = S_LEN_HI;
            end
            S_LEN_HI: if (acc) begin
                sum_d = sum_q + in_data;
                n_d = len_w[ADDR_W:0];
                state_d = (len_w == 16'd0 || len_w > 16'(MAX_WORDS)) ? S_ERR : S_DATA;
            end
            S_DATA: if (acc) begin
                sum_d = sum_q + in_data;
                word_d = {in_data, word_q[23:8]};
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    imem_we_d = 1'b1;
                    addr_d = wl_q[ADDR_W-1:0];
                    din_d = {in_data, word_q};
                    wl_d = wl_inc;
                    state_d = (wl_inc == n_q) ? S_CSUM : S_DATA;
                end
            end
            S_CSUM: if (acc) state_d = (in_data == sum_q) ? S_RUN : S_ERR;
            S_IDLE, S_RUN, S_ERR: if (sync) begin
                state_d = S_LEN_LO;
                wl_d = '0;
                sum_d = '0;
                idx_d = '0;
            end
            default: state_d = S_IDLE;
        endcase
        cpu_rst_d = state_d == S_RUN;
        done_d = state_d == S_RUN;
        err_d = state_d == S_ERR;
        busy_d = state_d inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_lo_q <= '0;
            n_q <= '0;
            sum_q <= '0;
            idx_q <= '0;
            word_q <= '0;
            wl_q <= '0;
            in_ready_q <= 1'b0;
            imem_we_q <= 1'b0;
            addr_q <= '0;
            din_q <= '0;
            cpu_rst_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_lo_q <= len_lo_d;
            n_q <= n_d;
            sum_q <= sum_d;
            idx_q <= idx_d;
            word_q <= word_d;
            wl_q <= wl_d;
            in_ready_q <= 1'b1;
            imem_we_q <= imem_we_d;
            addr_q <= addr_d;
            din_q <= din_d;
            cpu_rst_q <= cpu_rst_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign imem_we = imem_we_q;
    assign imem_addr = addr_q;
    assign imem_din = din_q;
    assign cpu_rst = cpu_rst_q;
    assign busy = busy_q;
    assign done = done_q;
    assign err = err_q;
    assign words_loaded = wl_q;
endmodule
